wide_add_sequencer: RTL
=======================

# wide_add_sequencer

Multi-cycle wide adder. It computes an (N*K)-bit sum by sequencing one internal N-bit `ripple_carry_adder` instance over K limbs, least significant limb first, and keeps the inter-limb carry in a register. It sits between a requester and a consumer, with a valid/ready handshake on each side. Wide additions reuse a single narrow adder instead of a K-times-longer carry chain.

## Interface
- `N`, default 8: limb width; passed to the internal `ripple_carry_adder`.
- `K`, default 4: number of limbs, K >= 1; operand width is W = N*K.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: block can accept a request.
- `a`, in, W: operand A.
- `b`, in, W: operand B.
- `cin`, in, 1: carry into limb 0.
- `sub`, in, 1: subtract select. It is ignored unless `WIDE_ADD_SUB_EN` is defined.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `sum`, out, W: result.
- `cout`, out, 1: carry out of the top limb.
- `busy`, out, 1: high in RUN and DONE.

## Operation
- Limb i of any W-bit vector is bits [i*N +: N].
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid` & `in_ready`:
    - latch `a`, `b`, `cin` and `sub` into operand registers;
    - carry_reg <= `cin`; idx <= 0;
    - go to RUN.
  - RUN: the adder gets A limb idx, B limb idx and carry_reg. Each cycle:
    - sum limb idx <= adder Sum;
    - carry_reg <= adder Cout;
    - idx <= idx+1.
    - When idx==K-1, cout <= adder Cout and go to DONE.
  - DONE: `out_valid`=1. `sum` and `cout` are held stable. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` outside IDLE is ignored and not queued.
- Operands are latched at accept. Changes to `a`, `b`, `cin` or `sub` during RUN or DONE have no effect.
- `out_ready` outside DONE has no effect.
- Arithmetic: {`cout`,`sum`} = A + B + cin, computed modulo 2^(W+1). Overflow is not flagged.
- idx width is max(1, clog2(K)). For K=1, RUN lasts exactly one cycle.
- `sum` keeps the last result through IDLE until limbs are overwritten by the next RUN.

## Timing
- Reset: `rst_n` low at a rising edge forces the following state. A reset mid-RUN or mid-DONE abandons the operation with no output.
  - state=IDLE, idx=0, carry_reg=0;
  - `sum`=0, `cout`=0;
  - `out_valid`=0, `busy`=0, `in_ready`=1 (decoded from state).
- Latency: accept at edge E0; `out_valid` is high after edge E0+K.
- Minimum request spacing is K+2 cycles, i.e. accept, K RUN cycles, one DONE cycle with `out_ready`=1, then back to IDLE. Back-to-back accept from DONE is not supported.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register: no combinational path from `in_valid` or `out_ready`.
- The adder path is combinational within one cycle: register to ripple_carry_adder to register.

## Configuration
- `WIDE_ADD_SUB_EN` defined: the latched `sub`=1 selects subtraction.
  - The adder B input is the inverted B limb.
  - carry_reg is initialised to 1 at accept and `cin` is ignored.
  - Result: `sum` = A - B mod 2^W; `cout`=1 means no borrow.
  - With `sub`=0, behaviour is addition as above.
- Not defined: the `sub` port is ignored (the port stays present). The B inversion logic is not built and only addition is performed.

## Test plan
- N=8, K=4, cin=0: a=0x000000FF, b=0x00000001 -> sum=0x00000100, cout=0. `out_valid` rises exactly 4 cycles after accept; `busy`=1 throughout.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1. This checks carry ripple through every limb boundary.
- a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
- Backpressure:
  - hold `out_ready`=0 for 3 cycles in DONE -> `sum`/`cout`/`out_valid` stable and `in_ready`=0;
  - `in_valid` pulsed during this time is ignored;
  - `out_ready`=1 -> IDLE next cycle with `in_ready`=1.
- Reset mid-RUN: assert `rst_n`=0 for one edge while idx=2 -> next cycle `out_valid`=0, `busy`=0, `in_ready`=1, `sum`=0. A new request then completes correctly.
- With `WIDE_ADD_SUB_EN`:
  - sub=1, a=0x10, b=0x01 -> sum=0x0000000F, cout=1;
  - sub=1, a=0, b=1 -> sum=0xFFFFFFFF, cout=0.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: (N*K)-bit adder that sequences one N-bit ripple adder over K limbs, LSB limb first.
// Optional subtraction support is built only when WIDE_ADD_SUB_EN is defined.
`default_nettype none

module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];
endmodule

module wide_add_sequencer #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic           busy
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic            carry_reg, cout_reg;
  logic [IW-1:0]   idx;
  logic [N-1:0]    a_limb, b_limb, add_b, add_sum;
  logic            add_cout, carry_init;

  // Limb mux over the latched operands, selected by the running limb index.
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < K; i++) begin
      if (idx == IW'(i)) begin
        a_limb = a_reg[i*N +: N];
        b_limb = b_reg[i*N +: N];
      end
    end
  end

`ifdef WIDE_ADD_SUB_EN
  logic sub_reg;

  // Subtraction is A + ~B + 1, so the incoming carry is forced to 1.
  assign add_b      = sub_reg ? ~b_limb : b_limb;
  assign carry_init = sub ? 1'b1 : cin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_reg <= sub;
    end
  end
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign add_b      = b_limb;
  assign carry_init = cin;
`endif

  ripple_carry_adder #(.N(N)) u_adder (
    .a    (a_limb),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= carry_init;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < K; i++) begin
            if (idx == IW'(i)) sum_reg[i*N +: N] <= add_sum;
          end
          carry_reg <= add_cout;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) cout_reg <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
endmodule

`default_nettype wire
